pwm_generator: RTL and testbench

//   Tick-driven PWM stage that consumes the frequency divider's ClkOut as a rate tick.

---
 rtl/pwm_generator_if.sv | 42 ++++
 rtl/pwm_generator.sv | 119 +++++++++++
 tb/tb_pwm_generator.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_generator_if.sv
// pwm_generator_if: bundles the configuration, tick and waveform signals of the
// tick-driven PWM stage so the stage and its driver share one port.
//   master modport : drives TickIn, Din, ConfigPeriod, ConfigDuty, Enable;
//                    observes PwmOut, PeriodDone, Count.
//   slave modport  : the PWM stage itself (mirror of master).
// Clock and reset are not part of the bundle; they stay plain module ports.
interface pwm_generator_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             TickIn;        // divider ClkOut, synchronous to Clk
   logic [WIDTH-1:0] Din;           // config data
   logic             ConfigPeriod;  // Din -> period pending register
   logic             ConfigDuty;    // Din -> duty pending register
   logic             Enable;        // 1 = run, 0 = idle
   logic             PwmOut;        // PWM waveform
   logic             PeriodDone;    // one-Clk pulse at each period wrap
   logic [WIDTH-1:0] Count;         // tick count within the current period

   modport master (
      output TickIn,
      output Din,
      output ConfigPeriod,
      output ConfigDuty,
      output Enable,
      input  PwmOut,
      input  PeriodDone,
      input  Count
   );

   modport slave (
      input  TickIn,
      input  Din,
      input  ConfigPeriod,
      input  ConfigDuty,
      input  Enable,
      output PwmOut,
      output PeriodDone,
      output Count
   );

endinterface

// File: rtl/pwm_generator.sv
// pwm_generator: tick-driven PWM stage.
//   Counts rising edges of bus.TickIn (the frequency divider's ClkOut) in the
//   Clk domain and produces bus.PwmOut, high while Count < active duty.
//   Period and duty are written into pending registers and copied into the
//   active registers only at a period wrap or while idle, so a running period
//   is never disturbed by a configuration write.
// Ports:
//   Clk   : system clock, all state on the rising edge
//   Reset : synchronous, active-high; clears every register
//   bus   : pwm_generator_if.slave (TickIn, Din, ConfigPeriod, ConfigDuty,
//           Enable in; PwmOut, PeriodDone, Count out)
module pwm_generator #(
   parameter int unsigned WIDTH = 32
) (
   input  logic            Clk,
   input  logic            Reset,
   pwm_generator_if.slave  bus
);

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_act_q, period_act_d;
   logic [WIDTH-1:0] duty_act_q, duty_act_d;
   logic [WIDTH-1:0] period_pend_q, period_pend_d;
   logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
   logic             period_done_q, period_done_d;
   logic             tick_prev_q;
   logic             tick;

   // One Clk of tick per rising edge of the divider output.
   assign tick = bus.TickIn & ~tick_prev_q;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      period_act_d  = period_act_q;
      duty_act_d    = duty_act_q;
      period_pend_d = period_pend_q;
      duty_pend_d   = duty_pend_q;
      period_done_d = 1'b0;

      // Writes land in the pending registers only; both may load in one cycle.
      if (bus.ConfigPeriod) begin
         period_pend_d = bus.Din;
      end
      if (bus.ConfigDuty) begin
         duty_pend_d = bus.Din;
      end

      unique case (state_q)
         StIdle: begin
            count_d      = '0;
            period_act_d = period_pend_q;
            duty_act_d   = duty_pend_q;
            // A tick in this cycle is not counted; counting starts next tick.
            if (bus.Enable && (period_act_q != '0)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!bus.Enable) begin
               // Disable wins over a coincident tick; partial period dropped.
               state_d = StIdle;
               count_d = '0;
            end else if (period_act_q == '0) begin
               // A zero period was latched at the last wrap.
               state_d = StIdle;
               count_d = '0;
            end else if (tick) begin
               if (count_q == (period_act_q - WIDTH'(1))) begin
                  count_d       = '0;
                  period_done_d = 1'b1;
                  period_act_d  = period_pend_q;
                  duty_act_d    = duty_pend_q;
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= StIdle;
         count_q       <= '0;
         period_act_q  <= '0;
         duty_act_q    <= '0;
         period_pend_q <= '0;
         duty_pend_q   <= '0;
         period_done_q <= 1'b0;
         tick_prev_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         period_act_q  <= period_act_d;
         duty_act_q    <= duty_act_d;
         period_pend_q <= period_pend_d;
         duty_pend_q   <= duty_pend_d;
         period_done_q <= period_done_d;
         tick_prev_q   <= bus.TickIn;
      end
   end

   // Outputs decode registered state only.
   assign bus.PwmOut     = (state_q == StRun) && (count_q < duty_act_q);
   assign bus.PeriodDone = period_done_q;
   assign bus.Count      = count_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed and randomized checks of pwm_generator against a
// behavioural model kept in the bench, plus waveform-level duty/period counts.
module tb_pwm_generator;

   logic clk;
   logic rst;

   pwm_generator_if #(.WIDTH(32)) bus ();

   pwm_generator #(.WIDTH(32)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   // Behavioural model state.
   bit          m_run;
   logic [31:0] m_cnt, m_pact, m_dact, m_ppend, m_dpend;
   bit          m_done;
   bit          m_tprev;

   // Stimulus helpers.
   bit          tick_rand;
   int unsigned phase;
   int unsigned pwm_hi;
   int unsigned done_n;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One Clk of the specified behaviour, using the inputs present at the edge.
   task automatic model_step();
      bit          tk;
      logic [31:0] old_ppend, old_dpend;
      old_ppend = m_ppend;
      old_dpend = m_dpend;
      if (rst) begin
         m_run = 0; m_cnt = 0; m_pact = 0; m_dact = 0;
         m_ppend = 0; m_dpend = 0; m_done = 0; m_tprev = 0;
      end else begin
         tk      = bus.TickIn && !m_tprev;
         m_tprev = bus.TickIn;
         if (bus.ConfigPeriod) m_ppend = bus.Din;
         if (bus.ConfigDuty) m_dpend = bus.Din;
         m_done = 0;
         if (!m_run) begin
            if (bus.Enable && m_pact != 0) m_run = 1;
            m_cnt  = 0;
            m_pact = old_ppend;
            m_dact = old_dpend;
         end else if (!bus.Enable || m_pact == 0) begin
            m_run = 0;
            m_cnt = 0;
         end else if (tk) begin
            if (m_cnt + 1 == m_pact) begin
               m_cnt  = 0;
               m_done = 1;
               m_pact = old_ppend;
               m_dact = old_dpend;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   task automatic step();
      if (tick_rand) bus.TickIn = 1'($urandom_range(0, 1));
      else bus.TickIn = (phase == 0);
      phase = (phase + 1) % 4;
      @(posedge clk);
      model_step();
      #1;
      bus.ConfigPeriod = 1'b0;
      bus.ConfigDuty   = 1'b0;
      check("pwm", 32'(bus.PwmOut), 32'(m_run && (m_cnt < m_dact)));
      check("done", 32'(bus.PeriodDone), 32'(m_done));
      check("count", bus.Count, m_cnt);
      pwm_hi += 32'(bus.PwmOut);
      done_n += 32'(bus.PeriodDone);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input bit p, input bit d, input logic [31:0] v);
      bus.ConfigPeriod = p;
      bus.ConfigDuty   = d;
      bus.Din          = v;
      step();
   endtask

   task automatic clear_stats();
      pwm_hi = 0;
      done_n = 0;
   endtask

   task automatic wait_done(input string tag);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         got = bus.PeriodDone;
      end
      check(tag, 32'(got), 32'd1);
   endtask

   task automatic wait_count(input string tag, input logic [31:0] v);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         got = (bus.Count == v);
      end
      check(tag, 32'(got), 32'd1);
   endtask

   initial begin
      rst              = 1'b1;
      bus.TickIn       = 1'b0;
      bus.Din          = '0;
      bus.ConfigPeriod = 1'b0;
      bus.ConfigDuty   = 1'b0;
      bus.Enable       = 1'b0;
      tick_rand        = 1'b1;
      phase            = 0;
      clear_stats();

      // T1: reset with random config and tick activity.
      for (int i = 0; i < 2; i++) begin
         bus.Din          = $urandom;
         bus.ConfigPeriod = 1'($urandom_range(0, 1));
         bus.ConfigDuty   = 1'($urandom_range(0, 1));
         bus.Enable       = 1'($urandom_range(0, 1));
         step();
      end
      check("t1_pwm", 32'(bus.PwmOut), 32'd0);
      check("t1_done", 32'(bus.PeriodDone), 32'd0);
      check("t1_count", bus.Count, 32'd0);
      rst        = 1'b0;
      bus.Enable = 1'b0;
      tick_rand  = 1'b0;
      phase      = 0;
      steps(2);

      // T2: period 4, duty 1, tick every 4 Clk.
      wr(1, 0, 32'd4);
      wr(0, 1, 32'd1);
      steps(2);
      bus.Enable = 1'b1;
      steps(8);
      clear_stats();
      steps(32);
      check("t2_pwm_hi", pwm_hi, 32'd8);
      check("t2_done_n", done_n, 32'd2);

      // T3: duty written mid-period takes effect from the next wrap.
      wait_done("t3_wrap0");
      steps(5);
      wr(0, 1, 32'd3);
      wait_done("t3_wrap1");
      clear_stats();
      steps(16);
      check("t3_pwm_hi", pwm_hi, 32'd12);

      // T4: duty extremes and period 1.
      wr(0, 1, 32'd0);
      wait_done("t4_wrap_d0");
      clear_stats();
      steps(32);
      check("t4_duty0", pwm_hi, 32'd0);
      wr(0, 1, 32'd9);
      wait_done("t4_wrap_d9");
      clear_stats();
      steps(32);
      check("t4_duty9", pwm_hi, 32'd32);
      wr(1, 0, 32'd1);
      wait_done("t4_wrap_p1");
      clear_stats();
      steps(32);
      check("t4_period1_done", done_n, 32'd8);

      // T5: disable mid-period, then enable with a zero period.
      wr(1, 1, 32'd4);
      wr(0, 1, 32'd1);
      wait_done("t5_wrap");
      wait_count("t5_cnt2", 32'd2);
      bus.Enable = 1'b0;
      clear_stats();
      step();
      check("t5_dis_count", bus.Count, 32'd0);
      check("t5_dis_pwm", 32'(bus.PwmOut), 32'd0);
      steps(8);
      check("t5_dis_done", done_n, 32'd0);
      wr(1, 0, 32'd0);
      steps(2);
      bus.Enable = 1'b1;
      clear_stats();
      steps(12);
      check("t5_p0_pwm", pwm_hi, 32'd0);
      check("t5_p0_count", bus.Count, 32'd0);

      // T6: reset mid-run clears pending config.
      wr(1, 0, 32'd4);
      steps(2);
      wait_count("t6_cnt2", 32'd2);
      rst = 1'b1;
      step();
      check("t6_rst_pwm", 32'(bus.PwmOut), 32'd0);
      check("t6_rst_count", bus.Count, 32'd0);
      check("t6_rst_done", 32'(bus.PeriodDone), 32'd0);
      rst = 1'b0;
      clear_stats();
      steps(12);
      check("t6_idle_pwm", pwm_hi, 32'd0);
      check("t6_idle_done", done_n, 32'd0);
      check("t6_idle_count", bus.Count, 32'd0);

      // Randomized run against the model.
      tick_rand = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.ConfigPeriod = 1'($urandom_range(0, 1));
            bus.ConfigDuty   = 1'($urandom_range(0, 1));
            bus.Din          = 32'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 31) == 0) bus.Enable = ~bus.Enable;
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
